cacheline_burst_adaptor: RTL and testbench
==========================================

# cacheline_burst_adaptor

Parametrised bridge between the last-level cache and burst-oriented main memory. It converts one full-line read or write request into BEATS memory beats of BURST_W bits, where BEATS = LINE_W/BURST_W. Beats may arrive with gaps between them. An optional critical-word-first ordering is available for reads. It sits between the LLC miss/writeback controller and the physical memory port.

## Interface
- LINE_W, 256, cacheline width in bits
- BURST_W, 64, memory beat width; LINE_W must be an integer multiple, BEATS ≥ 2 and a power of two
- ADDR_W, 32, address width
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset, synchronous, active-low
- line_i  in  LINE_W  write data from LLC
- line_o  out  LINE_W  read data to LLC
- address_i  in  ADDR_W  request address from LLC
- read_i, write_i  in  1  LLC request; held until resp_o is seen
- resp_o  out  1  one-cycle completion pulse
- burst_i  in  BURST_W  memory read beat
- burst_o  out  BURST_W  memory write beat
- address_o  out  ADDR_W  memory address
- read_o, write_o  out  1  memory request
- resp_i  in  1  beat accepted (write) or beat valid (read)

## Operation
- States: IDLE, RD, WR, DONE.
- **Reset values:** state=IDLE, beat counter=0, line buffer=0, address register=0. All outputs read 0: line_o, burst_o, address_o, read_o, write_o, resp_o.
- **IDLE:**
  - write_i=1 → latch line_i and address_i, go to WR. Write wins if read_i and write_i are both high.
  - Otherwise read_i=1 → latch address_i, go to RD.
  - Beat counter and beat index are cleared to 0 on acceptance.
- **RD:**
  - read_o=1.
  - On each cycle with resp_i=1, store burst_i into buffer slice [BURST_W*idx +: BURST_W] and increment the counter.
  - After the BEATS-th beat → DONE.
- **WR:**
  - write_o=1.
  - burst_o = buffer slice at the current idx, driven combinationally from the registered index.
  - On resp_i=1 the beat is consumed and the counter increments. After the BEATS-th beat → DONE.
- **Beat index:**
  - idx = (start + counter) mod BEATS.
  - start = 0, except as described under Configuration.
  - Counter width is clog2(BEATS)+1 so the terminal count BEATS is representable.
- **DONE:** resp_o=1 for exactly one cycle, then → IDLE. Requests seen during DONE are ignored.
- **Outputs held between requests:**
  - line_o is driven continuously from the buffer. It is valid from the DONE cycle until the next read acceptance.
  - address_o is driven from the address register.
- **address_o value:** address_i with its low clog2(LINE_W/8) bits cleared (line-aligned).
- **Reset mid-operation:** reset_n=0 aborts the transfer. Next cycle: IDLE, read_o=write_o=resp_o=0, buffer cleared.
- **resp_i outside RD/WR:** ignored.

## Timing
- Request sampled high in IDLE at cycle 0 → read_o or write_o high from cycle 1.
- read_o/write_o fall in the cycle after the final beat is accepted.
- With consecutive resp_i during cycles 1..BEATS, resp_o is high in cycle BEATS+1. Minimum total latency is BEATS+2 cycles, request to back-to-back re-acceptance.
- Each idle gap in resp_i adds exactly one cycle.
- Write beat timing: burst_o must change only on the edge at which a beat is accepted. It is stable while resp_i=0.

## Configuration
- Macro: CLA_CRITICAL_WORD_FIRST_EN.
- **Defined:**
  - For reads, start = address_i[clog2(LINE_W/8)-1 : clog2(BURST_W/8)].
  - address_o keeps those beat-offset bits, so only the byte-offset bits are cleared.
  - Beats fill the buffer in wrapping order start, start+1, …, start−1.
  - Writes are unchanged: start=0, line-aligned.
- **Undefined:** start=0 for all requests. The RTL for offset extraction is not compiled.

## Structure
- Shared package cla_pkg holds:
  - the state enum typedef (IDLE, RD, WR, DONE);
  - a function computing BEATS;
  - localparams for the offset bit positions.
- One sub-module is natural: cla_line_buffer. It is a LINE_W register written per slice by idx, with a parallel load for writes and a synchronous clear. The FSM and counter remain in the top.

## Test plan
- **Read, consecutive beats:** read_i=1, address_i=0x0000_1234; resp_i high for 4 cycles with burst_i=0x11…11, 0x22…22, 0x33…33, 0x44…44 → address_o=0x0000_1220, resp_o in cycle 5, line_o={0x44…44, 0x33…33, 0x22…22, 0x11…11}.
- **Write with gaps:** write_i=1, line_i={D3,D2,D1,D0}; resp_i pattern 1,0,1,0,0,1,1 → burst_o sequence D0,D1,D1,D2,D2,D2,D3; resp_o one cycle after the last beat; write_o low in that cycle.
- **Simultaneous request:** read_i=write_i=1 → write_o=1, read_o=0 throughout.
- **Reset mid-read:** reset_n=0 after 2 beats → all outputs 0 next cycle; a new read completes normally with counter restarting at 0.
- **Critical word first (CLA_CRITICAL_WORD_FIRST_EN defined):** read at address_i 0x0000_1230 → address_o=0x0000_1230; beats land in slots 2,3,0,1.
- **Parameter sweep:** LINE_W=512, BURST_W=64 → 8 beats; resp_o at cycle 9 with consecutive resp_i.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for cacheline_burst_adaptor and its line buffer.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_e;

  localparam int unsigned CLA_BYTE_W      = 8;
  localparam int unsigned CLA_DEF_LINE_W  = 256;
  localparam int unsigned CLA_DEF_BURST_W = 64;
  localparam int unsigned CLA_DEF_ADDR_W  = 32;

  function automatic int unsigned cla_beats(input int unsigned line_w, input int unsigned burst_w);
    return line_w / burst_w;
  endfunction

  // Number of address bits addressing a byte within a full line.
  function automatic int unsigned cla_line_off_bits(input int unsigned line_w);
    return $clog2(line_w / CLA_BYTE_W);
  endfunction

  // Number of address bits addressing a byte within one memory beat.
  function automatic int unsigned cla_beat_off_bits(input int unsigned burst_w);
    return $clog2(burst_w / CLA_BYTE_W);
  endfunction

endpackage

// File: rtl/cla_line_buffer.sv
// Line-wide data register: per-beat slice writes, parallel load and synchronous clear.
module cla_line_buffer
  import cla_pkg::*;
#(
  parameter int unsigned LINE_W  = CLA_DEF_LINE_W,
  parameter int unsigned BURST_W = CLA_DEF_BURST_W,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               wr_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [BURST_W-1:0] beat_i,
  output logic [LINE_W-1:0]  line_o,
  output logic [BURST_W-1:0] beat_o
);

  logic [LINE_W-1:0] line_d;
  logic [LINE_W-1:0] line_q;

  // Next-state: clear beats load beats a single-slice beat write.
  always_comb begin
    line_d = line_q;
    if (clr_i) begin
      line_d = '0;
    end else if (load_i) begin
      line_d = line_i;
    end else if (wr_i) begin
      line_d[idx_i*BURST_W +: BURST_W] = beat_i;
    end else begin
      line_d = line_q;
    end
  end

  // Line storage register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts one LLC line read/write into BEATS memory beats of BURST_W bits.
// Optional macro CLA_CRITICAL_WORD_FIRST_EN: reads start at the requested beat and wrap.
module cacheline_burst_adaptor
  import cla_pkg::*;
#(
  parameter int unsigned LINE_W  = CLA_DEF_LINE_W,
  parameter int unsigned BURST_W = CLA_DEF_BURST_W,
  parameter int unsigned ADDR_W  = CLA_DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned BEATS    = cla_beats(LINE_W, BURST_W);
  localparam int unsigned IDX_W    = $clog2(BEATS);
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam int unsigned LINE_OFF = cla_line_off_bits(LINE_W);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

  cla_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   start_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               read_q;
  logic               write_q;
  logic               resp_q;

  logic [IDX_W-1:0]   idx_s;
  logic [IDX_W-1:0]   rd_start_s;
  logic [ADDR_W-1:0]  rd_addr_s;
  logic               accept_wr_s;
  logic               accept_rd_s;
  logic               beat_wr_s;
  logic [BURST_W-1:0] buf_beat_s;
  logic [BURST_W-1:0] burst_s;

`ifdef CLA_CRITICAL_WORD_FIRST_EN
  localparam int unsigned       BEAT_OFF  = cla_beat_off_bits(BURST_W);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~((ADDR_W'(1) << BEAT_OFF) - ADDR_W'(1));

  // Reads begin at the beat holding the requested word; address keeps that offset.
  assign rd_start_s = address_i[LINE_OFF-1:BEAT_OFF];
  assign rd_addr_s  = address_i & BEAT_MASK;
`else
  assign rd_start_s = '0;
  assign rd_addr_s  = address_i & LINE_MASK;
`endif

  // Wraps naturally at BEATS because idx_s is only IDX_W bits wide.
  assign idx_s       = start_q + cnt_q[IDX_W-1:0];
  assign accept_wr_s = (state_q == IDLE) && write_i;
  assign accept_rd_s = (state_q == IDLE) && !write_i && read_i;
  assign beat_wr_s   = (state_q == RD) && resp_i;

  cla_line_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .IDX_W   (IDX_W)
  ) u_line_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (accept_rd_s),
    .load_i  (accept_wr_s),
    .line_i  (line_i),
    .wr_i    (beat_wr_s),
    .idx_i   (idx_s),
    .beat_i  (burst_i),
    .line_o  (line_o),
    .beat_o  (buf_beat_s)
  );

  // Request FSM, beat counter and registered memory/LLC handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (write_i) begin
            state_q <= WR;
            write_q <= 1'b1;
            addr_q  <= address_i & LINE_MASK;
            start_q <= '0;
            cnt_q   <= '0;
          end else if (read_i) begin
            state_q <= RD;
            read_q  <= 1'b1;
            addr_q  <= rd_addr_s;
            start_q <= rd_start_s;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RD: begin
          if (resp_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        WR: begin
          if (resp_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write beat only presented while a write burst is in flight.
  always_comb begin
    if (write_q) begin
      burst_s = buf_beat_s;
    end else begin
      burst_s = '0;
    end
  end

  assign burst_o   = burst_s;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench for cacheline_burst_adaptor: 4-beat instance plus an 8-beat instance.
module tb_cacheline_burst_adaptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;

  logic [511:0] line8_i, line8_o;
  logic [31:0]  address8_i, address8_o;
  logic         read8_i, write8_i, resp8_o, read8_o, write8_o, resp8_i;
  logic [63:0]  burst8_i, burst8_o;

  int checks = 0;
  int errors = 0;

  logic [255:0] sb_line[$];
  logic [31:0]  sb_addr[$];
  logic [63:0]  sb_beat[$];
  logic [255:0] last_line;

  cacheline_burst_adaptor dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(64), .ADDR_W(32)) dut8 (
    .clk(clk), .reset_n(reset_n), .line_i(line8_i), .line_o(line8_o),
    .address_i(address8_i), .read_i(read8_i), .write_i(write8_i), .resp_o(resp8_o),
    .burst_i(burst8_i), .burst_o(burst8_o), .address_o(address8_o),
    .read_o(read8_o), .write_o(write8_o), .resp_i(resp8_i)
  );

  // Reference model: first beat slot and memory address for a 256-bit line read.
  function automatic logic [1:0] model_start(input logic [31:0] addr);
`ifdef CLA_CRITICAL_WORD_FIRST_EN
    return addr[4:3];
`else
    return addr[4:3] & 2'b00;
`endif
  endfunction

  function automatic logic [31:0] model_rd_addr(input logic [31:0] addr);
`ifdef CLA_CRITICAL_WORD_FIRST_EN
    return addr & 32'hFFFF_FFF8;
`else
    return addr & 32'hFFFF_FFE0;
`endif
  endfunction

  function automatic logic [255:0] model_line(input logic [255:0] seq, input logic [1:0] start);
    logic [255:0] r;
    logic [1:0]   slot;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      slot = start + 2'(k);
      r[64*slot +: 64] = seq[64*k +: 64];
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  // Feeds read beats (beat k of seq in arrival order) following pat, until resp_o.
  task automatic drive_read_beats(input logic [255:0] seq, input logic [15:0] pat, input int npat,
                                  output int cyc, output bit tmo);
    int k;
    int p;
    k = 0; p = 0; cyc = 1; tmo = 1'b0;
    while (resp_o !== 1'b1) begin
      if (cyc > 40) begin
        tmo = 1'b1;
        break;
      end
      resp_i  = (p < npat) ? pat[p] : 1'b1;
      burst_i = (resp_i && k < 4) ? seq[64*k +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (resp_i) k++;
      p++;
      @(negedge clk);
      cyc++;
    end
    resp_i = 1'b0;
  endtask

  // Full read transaction from an idle negedge; returns at the negedge after resp_o.
  task automatic read_txn(input string nm, input logic [31:0] addr, input logic [255:0] seq,
                          input logic [15:0] pat, input int npat, input int exp_cyc);
    int cyc;
    bit tmo;
    logic [255:0] exp_l;
    logic [31:0]  exp_a;
    address_i = addr;
    read_i    = 1'b1;
    sb_line.push_back(model_line(seq, model_start(addr)));
    sb_addr.push_back(model_rd_addr(addr));
    @(negedge clk);
    checks++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      errors++; $display("FAIL %s_req read_o=%b write_o=%b required 1 0", nm, read_o, write_o);
    end
    exp_a = sb_addr.pop_front();
    checks++;
    if (address_o !== exp_a) begin
      errors++; $display("FAIL %s_addr address_o=%h required %h", nm, address_o, exp_a);
    end
    drive_read_beats(seq, pat, npat, cyc, tmo);
    checks++;
    if (tmo || cyc != exp_cyc) begin
      errors++; $display("FAIL %s_latency resp_o cycle %0d (timeout %0b) required %0d", nm, cyc, tmo, exp_cyc);
    end
    exp_l = sb_line.pop_front();
    checks++;
    if (line_o !== exp_l) begin
      errors++; $display("FAIL %s_line line_o=%h required %h", nm, line_o, exp_l);
    end
    checks++;
    if (read_o !== 1'b0) begin
      errors++; $display("FAIL %s_rd_fall read_o=%b required 0", nm, read_o);
    end
    last_line = exp_l;
    read_i = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL %s_pulse resp_o=%b required 0", nm, resp_o);
    end
  endtask

  // Write beats: compares burst_o against the scoreboard head every cycle, pops on accept.
  task automatic write_beats(input string nm, input logic [15:0] pat, input int npat);
    logic [63:0] exp_b;
    for (int p = 0; p < npat; p++) begin
      checks++;
      if (write_o !== 1'b1 || read_o !== 1'b0) begin
        errors++; $display("FAIL %s_wr_req write_o=%b read_o=%b required 1 0", nm, write_o, read_o);
      end
      exp_b = (sb_beat.size() > 0) ? sb_beat[0] : 64'hx;
      checks++;
      if (burst_o !== exp_b) begin
        errors++; $display("FAIL %s_beat%0d burst_o=%h required %h", nm, p, burst_o, exp_b);
      end
      resp_i = pat[p];
      if (pat[p] && sb_beat.size() > 0) void'(sb_beat.pop_front());
      @(negedge clk);
    end
    resp_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    read8_i = 1'b0; write8_i = 1'b0; resp8_i = 1'b0;
    line8_i = '0; address8_i = '0; burst8_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      errors++; $display("FAIL rst_data line_o=%h burst_o=%h address_o=%h required 0", line_o, burst_o, address_o);
    end
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL rst_ctrl rd/wr/resp=%b required 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line8_o !== '0 || {read8_o, write8_o, resp8_o, burst8_o, address8_o} !== '0) begin
      errors++; $display("FAIL rst_dut8 line8_o=%h ctrl=%b required 0", line8_o, {read8_o, write8_o, resp8_o});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL rst_idle rd/wr/resp=%b required 000", {read_o, write_o, resp_o});
    end
  endtask

  task automatic test_read_consecutive();
    logic [255:0] seq;
    seq = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    read_txn("rd_seq", 32'h0000_1234, seq, 16'h000F, 4, 5);
  endtask

  task automatic test_resp_idle();
    resp_i  = 1'b1;
    burst_i = 64'hFEED_FACE_FEED_FACE;
    repeat (3) @(negedge clk);
    resp_i = 1'b0;
    checks++;
    if (line_o !== last_line) begin
      errors++; $display("FAIL idle_resp line_o=%h required %h", line_o, last_line);
    end
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL idle_ctrl rd/wr/resp=%b required 000", {read_o, write_o, resp_o});
    end
  endtask

  task automatic test_read_gaps();
    read_txn("rd_gap", 32'h0000_0F7C, rand_line(), 16'h0059, 7, 8);
  endtask

  task automatic test_write_gaps();
    logic [255:0] d;
    d = rand_line();
    for (int k = 0; k < 4; k++) sb_beat.push_back(d[64*k +: 64]);
    line_i = d; address_i = 32'h0000_ABCD; write_i = 1'b1;
    @(negedge clk);
    checks++;
    if (address_o !== 32'h0000_ABC0) begin
      errors++; $display("FAIL wr_addr address_o=%h required 0000abc0", address_o);
    end
    write_beats("wr_gap", 16'h0065, 7);
    checks++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      errors++; $display("FAIL wr_done resp_o=%b write_o=%b required 1 0", resp_o, write_o);
    end
    checks++;
    if (sb_beat.size() != 0) begin
      errors++; $display("FAIL wr_drain beats left %0d required 0", sb_beat.size());
    end
    write_i = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_o !== 1'b0) begin
      errors++; $display("FAIL wr_pulse resp_o=%b required 0", resp_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [255:0] d;
    d = rand_line();
    for (int k = 0; k < 4; k++) sb_beat.push_back(d[64*k +: 64]);
    line_i = d; address_i = 32'h5555_5557; read_i = 1'b1; write_i = 1'b1;
    @(negedge clk);
    checks++;
    if (address_o !== 32'h5555_5540) begin
      errors++; $display("FAIL sim_addr address_o=%h required 55555540", address_o);
    end
    write_beats("simul", 16'h000F, 4);
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      errors++; $display("FAIL sim_done resp_o=%b read_o=%b required 1 0", resp_o, read_o);
    end
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] sa, sbq, exp_l;
    logic [31:0]  exp_a;
    int cyc;
    bit tmo;
    sa = rand_line(); sbq = rand_line();
    address_i = 32'h0000_0100; read_i = 1'b1;
    sb_line.push_back(model_line(sa, model_start(32'h0000_0100)));
    @(negedge clk);
    drive_read_beats(sa, 16'h000F, 4, cyc, tmo);
    exp_l = sb_line.pop_front();
    checks++;
    if (tmo || cyc != 5 || line_o !== exp_l) begin
      errors++; $display("FAIL b2b_first cycle %0d line_o=%h required 5 %h", cyc, line_o, exp_l);
    end
    address_i = 32'h0000_3318;
    sb_line.push_back(model_line(sbq, model_start(32'h0000_3318)));
    sb_addr.push_back(model_rd_addr(32'h0000_3318));
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle read_o=%b resp_o=%b required 0 0", read_o, resp_o);
    end
    @(negedge clk);
    exp_a = sb_addr.pop_front();
    checks++;
    if (read_o !== 1'b1 || address_o !== exp_a) begin
      errors++; $display("FAIL b2b_reaccept read_o=%b address_o=%h required 1 %h", read_o, address_o, exp_a);
    end
    drive_read_beats(sbq, 16'h000F, 4, cyc, tmo);
    exp_l = sb_line.pop_front();
    checks++;
    if (tmo || cyc != 5 || line_o !== exp_l) begin
      errors++; $display("FAIL b2b_second cycle %0d line_o=%h required 5 %h", cyc, line_o, exp_l);
    end
    read_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] s;
    s = rand_line();
    address_i = 32'h0000_2000; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = s[64*k +: 64];
      @(negedge clk);
    end
    reset_n = 1'b0; resp_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      errors++; $display("FAIL midrst_ctrl rd/wr/resp=%b required 000", {read_o, write_o, resp_o});
    end
    checks++;
    if (line_o !== '0 || address_o !== '0 || burst_o !== '0) begin
      errors++; $display("FAIL midrst_data line_o=%h address_o=%h required 0", line_o, address_o);
    end
    reset_n = 1'b1;
    read_txn("midrst_rd", 32'h0000_2468, rand_line(), 16'h000F, 4, 5);
  endtask

`ifdef CLA_CRITICAL_WORD_FIRST_EN
  task automatic test_cwf();
    logic [255:0] s;
    s = rand_line();
    read_txn("cwf", 32'h0000_1230, s, 16'h000F, 4, 5);
    checks++;
    if (line_o !== {s[127:64], s[63:0], s[255:192], s[191:128]} || address_o !== 32'h0000_1230) begin
      errors++; $display("FAIL cwf_slots line_o=%h address_o=%h required %h 00001230", line_o, address_o,
                         {s[127:64], s[63:0], s[255:192], s[191:128]});
    end
  endtask
`endif

  task automatic test_param_sweep();
    logic [511:0] s, exp_l;
    logic [31:0]  exp_a;
    logic [2:0]   start;
    int cyc;
    int k;
    for (int j = 0; j < 16; j++) s[32*j +: 32] = $urandom();
`ifdef CLA_CRITICAL_WORD_FIRST_EN
    start = 3'd1; exp_a = 32'h0000_4008;
`else
    start = 3'd0; exp_a = 32'h0000_4000;
`endif
    exp_l = '0;
    for (int j = 0; j < 8; j++) exp_l[64*(3'(start + 3'(j))) +: 64] = s[64*j +: 64];
    address8_i = 32'h0000_4008; read8_i = 1'b1;
    @(negedge clk);
    checks++;
    if (read8_o !== 1'b1 || address8_o !== exp_a) begin
      errors++; $display("FAIL p8_req read8_o=%b address8_o=%h required 1 %h", read8_o, address8_o, exp_a);
    end
    cyc = 1; k = 0;
    while (resp8_o !== 1'b1 && cyc <= 40) begin
      resp8_i  = 1'b1;
      burst8_i = (k < 8) ? s[64*k +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      k++;
      @(negedge clk);
      cyc++;
    end
    resp8_i = 1'b0; read8_i = 1'b0;
    checks++;
    if (resp8_o !== 1'b1 || cyc != 9) begin
      errors++; $display("FAIL p8_latency resp8_o cycle %0d required 9", cyc);
    end
    checks++;
    if (line8_o !== exp_l) begin
      errors++; $display("FAIL p8_line line8_o=%h required %h", line8_o, exp_l);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_consecutive();
    test_resp_idle();
    test_read_gaps();
    test_write_gaps();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_read();
`ifdef CLA_CRITICAL_WORD_FIRST_EN
    test_cwf();
`endif
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
